out_post: RTL
=============

# out_post

Post-processing stage downstream of the sample controller's output-read sequence. Each cycle `outr` is high, the block takes one accumulator word for output channel `ra` at output-buffer address `oa`. It adds the per-channel bias, applies a rounding arithmetic right shift, optional ReLU and signed saturation, then writes the result into the destination buffer. The result is the layer output that the batch controller later streams out.

## Interface
Parameters:
- `DW`, 32, accumulator word width (signed)
- `OW`, 16, output/bias word width (signed)
- `NCH`, 16, number of output channels (bias entries); address width 4

Ports. Clock `clk`; reset `rst_n` is asynchronous and active-low.
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous active-low reset
- `outr` in 1: input element valid this cycle
- `ra` in 4: channel index of the element
- `oa` in 13: destination address of the element
- `acc` in DW: signed accumulator value, aligned with `outr`/`ra`/`oa`
- `od` in 4: last channel index (channels 0..od)
- `shift` in 4: right-shift amount 0..15
- `relu_en` in 1: clamp negatives to 0
- `bwe` in 1: bias write enable
- `bwa` in 4: bias write address
- `bwd` in OW: bias write data (signed)
- `clr_cnt` in 1: clear saturation counter
- `dst_we` out 1: destination write strobe
- `dst_wa` out 13: destination write address
- `dst_wd` out OW: destination write data
- `done` out 1: one-cycle pulse with the write of channel `od`
- `busy` out 1: any pipeline stage valid
- `sat_cnt` out 16: count of saturated results

## Operation
- Bias store: NCH×OW registers, reset to 0. Written when `bwe`.
- S1 (register): `v1<=outr`; capture `acc`, `ra`, `oa`, and `b1=bias[ra]`.
  - If `bwe && bwa==ra` in the same cycle, `b1=bwd`. The write bypasses to the read.
- S2: `sum = sext(acc,DW+2) + sext(b1,DW+2)`.
  - Rounding term `r = (shift==0) ? 0 : 1<<(shift-1)` is added in the same stage: `t2 = sum + r`.
  - Register `t2`, `oa`, `last2 = (ra==od)`, and `v2`.
- S3: `q = t2 >>> shift` (arithmetic).
  - If `relu_en && q<0`: `q=0`.
  - If `q > 2^(OW-1)-1`: `q = 2^(OW-1)-1`, sat flag set.
  - If `q < -2^(OW-1)`: `q = -2^(OW-1)`, sat flag set.
  - Register `dst_wd=q[OW-1:0]`, `dst_wa=oa`, `dst_we=v2`, `done=v2&last2`.
- `sat_cnt` increments when the S3 result is valid and saturated. It sticks at 0xFFFF and does not wrap.
  - `clr_cnt` has priority: when `clr_cnt` and an increment coincide, the result is 0.
- `busy = v1|v2|dst_we`.
- `od`, `shift`, `relu_en` are sampled at the stage that uses them. They must be held stable while `busy`.
- No backpressure. The destination accepts a write every cycle. Back-to-back `outr` is processed at full rate.

## Timing
- Reset (async assert, sync-used deassert) gives:
  - `dst_we=0`, `dst_wa=0`, `dst_wd=0`, `done=0`, `busy=0`, `sat_cnt=0`.
  - All stage valids 0 and all bias entries 0.
  - Reset mid-burst discards in-flight elements. No `dst_we` follows deassertion until new `outr`.
- Latency: `outr` sampled at edge N gives `dst_we`/`dst_wa`/`dst_wd` high/valid during the cycle after edge N+2 (3 registers).
- Throughput: 1 element/cycle. Gaps in `outr` propagate as gaps in `dst_we`.
- `done` is coincident with the `dst_we` carrying `ra==od`. The same cycle as that write sees `sat_cnt` still at its pre-update value; it updates one edge later.
- Bias write to an address other than `ra` takes effect for reads from the next cycle.
- `shift==0`: no rounding term, and `t2>>>0` passes through unchanged.
- Width: DW+2 internal bits guarantee no overflow of acc+bias+round for DW=32, OW=16.

## Test plan
- Pass-through: bias 0, shift 0, relu off, `outr` with acc=100, ra=0, oa=7 -> 3 cycles later dst_we=1, dst_wa=7, dst_wd=100.
- Sign/ReLU: acc=-5 -> dst_wd=0xFFFB with relu off; dst_wd=0x0000 with relu on; sat_cnt stays 0.
- Saturation: acc=40000 -> 0x7FFF, sat_cnt=1. Then acc=-40000 (relu off) -> 0x8000, sat_cnt=2. Then `clr_cnt` coincident with a saturating result -> sat_cnt=0.
- Rounding/bias: shift=2, bias[1]=2, acc=6, ra=1 -> (8+2)>>2=2. Then acc=-12, bias 0 -> (-12+2)>>>2=-3, dst_wd=0xFFFD.
- Burst + done + bypass:
  - Stimulus: od=3, back-to-back ra=0..3, oa=5,15,25,35, acc=10 each, and `bwe` with bwa=2, bwd=4 in the cycle ra=2 is presented.
  - Expected: four consecutive writes with data 10,10,14,10 at 5,15,25,35. `done` is high only with the address-35 write. `busy` falls the cycle after.
- Reset mid-burst: assert rst_n low between the 2nd and 3rd element of a 4-element burst -> all outputs 0 immediately, no further dst_we, bias entries read back 0.

Source files
------------

// File: rtl/out_post.sv
// ============================================================================
//  Module   : out_post
//  Purpose  : Output post-processing: bias add, rounding shift, ReLU, saturate.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module out_post #(
    parameter int DW  = 32,
    parameter int OW  = 16,
    parameter int NCH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 outr,
    input  logic [3:0]           ra,
    input  logic [12:0]          oa,
    input  logic signed [DW-1:0] acc,
    input  logic [3:0]           od,
    input  logic [3:0]           shift,
    input  logic                 relu_en,
    input  logic                 bwe,
    input  logic [3:0]           bwa,
    input  logic signed [OW-1:0] bwd,
    input  logic                 clr_cnt,
    output logic                 dst_we,
    output logic [12:0]          dst_wa,
    output logic [OW-1:0]        dst_wd,
    output logic                 done,
    output logic                 busy,
    output logic [15:0]          sat_cnt
);

    localparam int TW = DW + 2;
    localparam logic [OW-1:0]        OMAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0]        OMIN = {1'b1, {(OW-1){1'b0}}};
    localparam logic signed [TW-1:0] QMAX = {{(TW-OW){1'b0}}, OMAX};
    localparam logic signed [TW-1:0] QMIN = {{(TW-OW){1'b1}}, OMIN};

    logic signed [OW-1:0] r_bias [NCH];

    logic                 r_v1;
    logic signed [DW-1:0] r_acc;
    logic [3:0]           r_ra;
    logic [12:0]          r_oa1;
    logic signed [OW-1:0] r_b1;

    logic                 r_v2;
    logic signed [TW-1:0] r_t2;
    logic [12:0]          r_oa2;
    logic                 r_last2;
    logic                 r_sat3;

    logic signed [OW-1:0] w_b1;
    logic [TW-1:0]        w_rnd;
    logic signed [TW-1:0] w_t2;
    logic signed [TW-1:0] w_q;
    logic [OW-1:0]        w_res;
    logic                 w_sat;

    // Same-cycle write to the channel being read is forwarded to the read.
    assign w_b1 = (bwe && (bwa == ra)) ? bwd : r_bias[ra];

    assign w_rnd = (shift == 4'd0) ? '0 : (TW'(1) << (shift - 4'd1));
    assign w_t2  = {{2{r_acc[DW-1]}}, r_acc}
                 + {{(TW-OW){r_b1[OW-1]}}, r_b1}
                 + w_rnd;

    assign w_q = r_t2 >>> shift;

    always_comb begin
        w_res = w_q[OW-1:0];
        w_sat = 1'b0;
        if (relu_en && w_q[TW-1]) begin
            w_res = '0;
        end else if (w_q > QMAX) begin
            w_res = OMAX;
            w_sat = 1'b1;
        end else if (w_q < QMIN) begin
            w_res = OMIN;
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_bias[i] <= '0;
            end
        end else if (bwe) begin
            r_bias[bwa] <= bwd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_acc   <= '0;
            r_ra    <= '0;
            r_oa1   <= '0;
            r_b1    <= '0;
            r_v2    <= 1'b0;
            r_t2    <= '0;
            r_oa2   <= '0;
            r_last2 <= 1'b0;
            dst_we  <= 1'b0;
            dst_wa  <= '0;
            dst_wd  <= '0;
            done    <= 1'b0;
            r_sat3  <= 1'b0;
        end else begin
            r_v1    <= outr;
            r_acc   <= acc;
            r_ra    <= ra;
            r_oa1   <= oa;
            r_b1    <= w_b1;
            r_v2    <= r_v1;
            r_t2    <= w_t2;
            r_oa2   <= r_oa1;
            r_last2 <= (r_ra == od);
            dst_we  <= r_v2;
            dst_wa  <= r_oa2;
            dst_wd  <= w_res;
            done    <= r_v2 & r_last2;
            r_sat3  <= r_v2 & w_sat;
        end
    end

    // Counter updates one edge after the write it reflects; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (clr_cnt) begin
            sat_cnt <= '0;
        end else if (dst_we && r_sat3 && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end

    assign busy = r_v1 | r_v2 | dst_we;

endmodule

`default_nettype wire
